// File: rtl/bin2bcd_seq_if.sv
// Start/ready/valid handshake bundle for the sequential binary-to-BCD converter.
// The master side issues conversions; the slave side is the converter.
interface bin2bcd_seq_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  ready;
    logic                  valid;
    logic [4*DIGITS-1:0]   bcd;
    logic                  err;

    modport master (
        output start, bin,
        input  ready, valid, bcd, err
    );

    modport slave (
        input  start, bin,
        output ready, valid, bcd, err
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Optional BIN2BCD_CHECK_EN adds a sticky digit-range (digit > 9) self-check on err.
//
// state | meaning
// IDLE  | ready=1, waiting for start; capture bin on start
// SHIFT | adjust digits >= 5 by +3, shift one bit of bin_sh into work
// DONE  | publish work on bcd, pulse valid, return to IDLE
module bin2bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input logic           clk,
    input logic           rst_n,
    bin2bcd_seq_if.slave  bus
);
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state;
    logic [BIN_W-1:0]   bin_sh;
    logic [BCD_W-1:0]   work;
    logic [BCD_W-1:0]   work_adj;
    logic [BCD_W-1:0]   bcd_r;
    logic [CNT_W-1:0]   cnt;
    logic               ready_r;
    logic               valid_r;

    always_comb begin
        work_adj = work;
        for (int d = 0; d < DIGITS; d++) begin
            if (work[4*d +: 4] >= 4'd5)
                work_adj[4*d +: 4] = work[4*d +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bin_sh  <= '0;
            work    <= '0;
            cnt     <= '0;
            bcd_r   <= '0;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bin_sh  <= bus.bin;
                        work    <= '0;
                        cnt     <= CNT_W'(BIN_W);
                        ready_r <= 1'b0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // MSB of the adjusted work register falls off; DIGITS guarantees it is 0
                    {work, bin_sh} <= {work_adj, bin_sh} << 1;
                    cnt            <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1))
                        state <= DONE;
                end
                DONE: begin
                    bcd_r   <= work;
                    valid_r <= 1'b1;
                    ready_r <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    ready_r <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready = ready_r;
    assign bus.valid = valid_r;
    assign bus.bcd   = bcd_r;

`ifdef BIN2BCD_CHECK_EN
    logic digit_bad;
    logic err_r;

    always_comb begin
        digit_bad = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (work[4*d +: 4] > 4'd9)
                digit_bad = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_r <= 1'b0;
        else if (state == DONE && digit_bad)
            err_r <= 1'b1;
    end

    assign bus.err = err_r;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: a cycle model pushes expected results on
// accepted starts; a negedge monitor pops and compares on every valid pulse.
module tb_bin2bcd_seq;
    localparam int BIN_W  = 8;
    localparam int DIGITS = 3;
    localparam int LAT    = BIN_W + 1;
    localparam int PERIOD = BIN_W + 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    bin2bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [11:0] bcd;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc     = 0;
    int          m_cnt   = 0;
    int          acc_cnt = 0;
    int          n_pass  = 0;
    int          n_total = 0;
    logic [11:0] exp_next = '0;
    logic [11:0] held     = '0;

    always #5 clk = ~clk;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_total++;
        if (act == req)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic timeout_fail(input string name);
        n_total++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // Reference handshake model: accepts start only when idle, result due LAT edges later
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb.delete();
            m_cnt = 0;
            held  = '0;
        end else begin
            cyc++;
            if (m_cnt == 0) begin
                if (bus.start) begin
                    sb.push_back('{exp_next, cyc + LAT});
                    m_cnt = LAT;
                    acc_cnt++;
                end
            end else begin
                m_cnt--;
            end
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            chk("ready", int'(bus.ready), int'(m_cnt == 0));
            if (bus.valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_valid", int'(bus.valid), 0);
                end else begin
                    e = sb.pop_front();
                    chk("bcd", int'(bus.bcd), int'(e.bcd));
                    chk("valid_cycle", cyc, e.cyc);
                    chk("err", int'(bus.err), 0);
                    held = e.bcd;
                end
            end else begin
                chk("bcd_hold", int'(bus.bcd), int'(held));
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (m_cnt != 0 && n < 2 * PERIOD) begin
            @(negedge clk);
            n++;
        end
        if (m_cnt != 0) timeout_fail("wait_idle");
    endtask

    task automatic issue(input logic [7:0] b, input logic [11:0] e);
        @(negedge clk);
        bus.bin   = b;
        exp_next  = e;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, t;
        bus.start = 1'b0;
        bus.bin   = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", int'(bus.ready), 1);
        chk("rst_valid", int'(bus.valid), 0);
        chk("rst_bcd",   int'(bus.bcd),   0);
        chk("rst_err",   int'(bus.err),   0);
        @(negedge clk);
        rst_n = 1'b1;

        // boundary and directed values
        issue(8'd0,   12'h000); wait_idle();
        issue(8'd255, 12'h255); wait_idle();
        issue(8'd99,  12'h099); wait_idle();
        issue(8'd100, 12'h100); wait_idle();

        // start and bin toggled mid-conversion must be ignored
        issue(8'd200, 12'h200);
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 8'd7;
        exp_next  = 12'h007;
        repeat (2) @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);

        // async reset during the 4th shift cycle discards the conversion
        issue(8'd123, 12'h123);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_ready", int'(bus.ready), 1);
        chk("abort_valid", int'(bus.valid), 0);
        chk("abort_bcd",   int'(bus.bcd),   0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (2 * PERIOD) @(negedge clk);

        // start held high, exhaustive sweep back-to-back
        for (int i = 0; i < 256; i++) begin
            bus.bin   = 8'(i);
            exp_next  = to_bcd(i);
            bus.start = 1'b1;
            t = acc_cnt;
            n = 0;
            while (acc_cnt == t && n < 2 * PERIOD) begin
                @(negedge clk);
                n++;
            end
            if (acc_cnt == t) timeout_fail("sweep_accept");
        end
        bus.start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);

        chk("drain", sb.size(), 0);
        chk("err_final", int'(bus.err), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
